// File: rtl/fft_frame_sequencer.sv
// Spectrum pipeline sequencer: sample capture, one-shot FFT start/collect, and tear-free
// double-buffer bank swap on the synchronised vsync falling edge, with drop/timeout accounting.
module fft_frame_sequencer #(
    parameter int POINTS  = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 4096,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              vsync,
    input  logic              fft_done,
    output logic              sample_we,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              fft_start,
    output logic              fft_busy,
    output logic              result_latch,
    output logic              display_swap,
    output logic              front_bank,
    output logic [15:0]       frame_count,
    output logic [DROP_W-1:0] drop_count,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter is cleared in START, so this value makes timeout_err rise TIMEOUT cycles after fft_start.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(POINTS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, START, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                terr_q, terr_d;
    logic                pend_q, pend_d;
    logic                latch_q, latch_d;
    logic                staged_q, staged_d;
    logic                swap_q, swap_d;
    logic                front_q, front_d;
    logic [15:0]         frame_q, frame_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                vs1_q, vs2_q, vs3_q;
    logic                latch_req, vs_fall, swap_now, fire_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            pend_q   <= 1'b0;
            latch_q  <= 1'b0;
            staged_q <= 1'b0;
            swap_q   <= 1'b0;
            front_q  <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
            vs1_q    <= 1'b0;
            vs2_q    <= 1'b0;
            vs3_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            pend_q   <= pend_d;
            latch_q  <= latch_d;
            staged_q <= staged_d;
            swap_q   <= swap_d;
            front_q  <= front_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            vs1_q    <= vsync;
            vs2_q    <= vs1_q;
            vs3_q    <= vs2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        latch_req = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (enable) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (sample_tick) begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (fft_done || cnt_q == CNT_LAST) begin
                    latch_req = fft_done;
                    terr_d    = terr_q | ~fft_done;
                    idx_d     = '0;
                    state_d   = enable ? CAPTURE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A swap wins over a coincident latch; the latch retries next cycle into the new back bank.
        vs_fall  = vs3_q & ~vs2_q;
        swap_now = vs_fall & staged_q;
        fire_now = (latch_req | pend_q) & ~swap_now;
        pend_d   = (latch_req | pend_q) & swap_now;
        swap_d   = swap_now;
        latch_d  = fire_now;
        front_d  = front_q ^ swap_now;
        frame_d  = swap_now ? frame_q + 16'd1 : frame_q;
        staged_d = staged_q & ~swap_now;
        drop_d   = drop_q;
        if (fire_now) begin
            staged_d = 1'b1;
            if (staged_q && !(&drop_q)) drop_d = drop_q + 1'b1;
        end
    end

    assign sample_we    = we_q;
    assign sample_addr  = addr_q;
    assign fft_start    = (state_q == START);
    assign fft_busy     = (state_q == START) || (state_q == RUN);
    assign result_latch = latch_q;
    assign display_swap = swap_q;
    assign front_bank   = front_q;
    assign frame_count  = frame_q;
    assign drop_count   = drop_q;
    assign timeout_err  = terr_q;
endmodule
